vmicro16_apb_wbuf: RTL and testbench
====================================

Name: vmicro16_apb_wbuf

Overview:
- Posted-write buffer between one cluster APB master port and one main-interconnect slave port.
- Writes are acknowledged locally and queued in a small FIFO. The FIFO drains onto the main bus in order, so cores do not stall on main-bus arbitration.
- Reads are forwarded only after the queue has drained, which preserves program order. Read data returns to the cluster after the main-bus read completes.
- One instance per cluster, between cluster M_P* and main interconnect S_P*[n].

Parameters:
- BUS_WIDTH, 16, APB address width.
- DATA_WIDTH, 16, APB data width.
- DEPTH, 4, write FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- S_PADDR  in  BUS_WIDTH  upstream (cluster) address.
- S_PWRITE  in  1  upstream write strobe.
- S_PSELx  in  1  upstream select.
- S_PENABLE  in  1  upstream access phase.
- S_PWDATA  in  DATA_WIDTH  upstream write data.
- S_PRDATA  out  DATA_WIDTH  read data to cluster.
- S_PREADY  out  1  transfer complete to cluster.
- M_PADDR  out  BUS_WIDTH  downstream address.
- M_PWRITE  out  1  downstream write.
- M_PSELx  out  1  downstream select.
- M_PENABLE  out  1  downstream access phase.
- M_PWDATA  out  DATA_WIDTH  downstream write data.
- M_PRDATA  in  DATA_WIDTH  downstream read data.
- M_PREADY  in  1  downstream ready.
- wb_idle  out  1  FIFO empty and master FSM idle.

Behaviour:
Reset:
- While reset is high, all state is cleared asynchronously and the FIFO is flushed.
- Any in-flight downstream transfer is abandoned; there is no replay.
- Output values during reset: M_PSELx=0, M_PENABLE=0, M_PWRITE=0, M_PADDR=0, M_PWDATA=0, S_PRDATA=0, S_PREADY=0, wb_idle=1.

Upstream write acceptance:
- Access cycle is defined as S_PSELx & S_PENABLE.
- On a write access cycle, S_PREADY = !full; this is combinational from the FIFO full flag.
- When S_PREADY is high in that cycle, {S_PADDR, S_PWDATA} is pushed.
- When the FIFO is full, S_PREADY stays low and the upstream master waits. No push occurs until an entry frees.

Upstream read:
- A read access cycle sets rd_pend=1 and latches S_PADDR. rd_pend is not set again while it is already set.
- A read is issued downstream only when rd_pend=1, the FIFO is empty and the FSM is in M_IDLE.
- On read completion, S_PRDATA is registered with M_PRDATA and S_PREADY pulses high for exactly one cycle (rd_done). rd_pend clears in the same cycle.
- S_PRDATA holds its value until the next read completes.

Master FSM (2-bit): M_IDLE, M_SETUP, M_ACCESS.
- M_IDLE -> M_SETUP when the FIFO is non-empty (source = head entry, M_PWRITE=1) or a read is eligible (M_PWRITE=0). The FIFO has priority.
- M_SETUP: M_PSELx=1, M_PENABLE=0. Always -> M_ACCESS.
- M_ACCESS: M_PSELx=1, M_PENABLE=1. Addr, data and M_PWRITE are held stable.
- In M_ACCESS with M_PREADY=1: pop the FIFO if this was a write, or complete the read if this was a read. Then -> M_IDLE.
- In M_ACCESS with M_PREADY=0: wait indefinitely.
- M_PADDR, M_PWDATA and M_PWRITE are registered when entering M_SETUP. They return to 0 in M_IDLE.
- Back-to-back transfers have no gap beyond the mandatory M_IDLE cycle, so each transfer takes at least 3 cycles.

Latency:
- Write: accepted at cycle T (empty FIFO, FSM idle) -> M_SETUP at T+2, M_ACCESS at T+3.
- Read on an empty FIFO: access cycle at T -> M_SETUP at T+2, M_ACCESS at T+3. M_PREADY at T+3 gives S_PREADY/S_PRDATA at T+4.

FIFO:
- Pointers are log2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH+1) bits.
- full = (count==DEPTH); empty = (count==0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- A push while full is impossible, because S_PREADY is gated by !full.

wb_idle = empty & (state==M_IDLE) & !rd_pend.

Decomposition:
- Shared config header gets the M_IDLE/M_SETUP/M_ACCESS encodings as `define constants, plus `WBUF_DEPTH default 4.
- Sub-module vmicro16_wbuf_fifo: synchronous register FIFO with async reset. Parameters are WIDTH=BUS_WIDTH+DATA_WIDTH and DEPTH. Ports are push, pop, din, dout (head), full, empty, count.
- The top level holds the read-pending logic and the master FSM.

Test Plan:
- Single write: S write addr 0x0810 data 0xBEEF -> S_PREADY=1 in the access cycle. M_SETUP 2 cycles later with M_PADDR=0x0810, M_PWDATA=0xBEEF, M_PWRITE=1; wb_idle returns to 1 after M_PREADY.
- Fill and stall: 5 back-to-back writes (data 1..5) with M_PREADY held 0 -> the first 4 are acked. The 5th waits with S_PREADY=0 until one M_PREADY pulse, then is acked. Downstream order is 1,2,3,4,5.
- Read ordering: writes 0xAAAA to 0x0800 then a read of 0x0800 -> the read appears on M only after the write's M_PREADY. The model returns 0xAAAA, giving S_PRDATA=0xAAAA with a one-cycle S_PREADY.
- Read latency: empty FIFO, read at 0x0820, model ready immediately with 0x1234 -> S_PREADY high exactly 4 cycles after the S access cycle; S_PRDATA=0x1234.
- Push/pop collision: FIFO count=2, S write accepted in the same cycle M_PREADY pops -> count stays 2 and pointers both advance. The data sequence is preserved.
- Reset mid-transfer: assert reset in M_ACCESS with 3 entries queued -> M_PSELx/M_PENABLE drop immediately (asynchronously), FIFO empty, wb_idle=1. The first post-reset write drains normally.

Source files
------------

// File: rtl/vmicro16_apb_wbuf_pkg.sv
// Shared types and defaults for the APB posted-write buffer.
// Master FSM state encoding and default buffer geometry.
package vmicro16_apb_wbuf_pkg;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } m_state_t;

  localparam int WBUF_DEPTH      = 4;
  localparam int WBUF_BUS_WIDTH  = 16;
  localparam int WBUF_DATA_WIDTH = 16;

endpackage

// File: rtl/vmicro16_wbuf_fifo.sv
// Register FIFO holding posted {addr, data} writes.
// Ports: clk, reset (async high), push/din, pop/dout (head),
//        full, empty, count.
module vmicro16_wbuf_fifo
  import vmicro16_apb_wbuf_pkg::*;
#(
  parameter int WIDTH = WBUF_BUS_WIDTH + WBUF_DATA_WIDTH,
  parameter int DEPTH = WBUF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves count unchanged
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vmicro16_apb_wbuf.sv
// Posted-write buffer between a cluster APB master and a main-bus slave.
// S_*: upstream (cluster) APB slave side, M_*: downstream APB master
// side, wb_idle: FIFO empty, FSM idle and no read pending.
module vmicro16_apb_wbuf
  import vmicro16_apb_wbuf_pkg::*;
#(
  parameter int BUS_WIDTH  = WBUF_BUS_WIDTH,
  parameter int DATA_WIDTH = WBUF_DATA_WIDTH,
  parameter int DEPTH      = WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic [BUS_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY,
  output logic                  wb_idle
);

  localparam int FW = BUS_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);

  m_state_t             state;
  logic                 s_access;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_count;
  logic [FW-1:0]        head;
  logic                 rd_pend;
  logic                 rd_done;
  logic                 rd_req;
  logic [BUS_WIDTH-1:0] rd_addr;
  logic                 xfer_done;
  logic                 rd_complete;

  assign s_access    = S_PSELx & S_PENABLE;
  assign push        = s_access & S_PWRITE & ~full;
  // the master still holds the read access during the rd_done
  // cycle; do not treat it as a fresh request
  assign rd_req      = s_access & ~S_PWRITE & ~rd_pend & ~rd_done;
  assign xfer_done   = (state == M_ACCESS) & M_PREADY;
  assign pop         = xfer_done & M_PWRITE;
  assign rd_complete = xfer_done & ~M_PWRITE;

  assign S_PREADY = push | rd_done;
  assign wb_idle  = (fifo_count == '0) & (state == M_IDLE) & ~rd_pend;

  vmicro16_wbuf_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({S_PADDR, S_PWDATA}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_done  <= 1'b0;
      rd_addr  <= '0;
      S_PRDATA <= '0;
    end else begin
      rd_done <= rd_complete;
      if (rd_complete) begin
        rd_pend  <= 1'b0;
        S_PRDATA <= M_PRDATA;
      end else if (rd_req) begin
        rd_pend <= 1'b1;
        rd_addr <= S_PADDR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= M_IDLE;
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWRITE  <= 1'b0;
      M_PADDR   <= '0;
      M_PWDATA  <= '0;
    end else begin
      unique case (state)
        M_IDLE: begin
          // queued writes drain before any read to keep order
          if (!empty) begin
            state    <= M_SETUP;
            M_PSELx  <= 1'b1;
            M_PWRITE <= 1'b1;
            M_PADDR  <= head[FW-1:DATA_WIDTH];
            M_PWDATA <= head[DATA_WIDTH-1:0];
          end else if (rd_pend) begin
            state    <= M_SETUP;
            M_PSELx  <= 1'b1;
            M_PWRITE <= 1'b0;
            M_PADDR  <= rd_addr;
            M_PWDATA <= '0;
          end
        end
        M_SETUP: begin
          state     <= M_ACCESS;
          M_PENABLE <= 1'b1;
        end
        M_ACCESS: begin
          if (M_PREADY) begin
            state     <= M_IDLE;
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PWRITE  <= 1'b0;
            M_PADDR   <= '0;
            M_PWDATA  <= '0;
          end
        end
        default: begin
          state     <= M_IDLE;
          M_PSELx   <= 1'b0;
          M_PENABLE <= 1'b0;
          M_PWRITE  <= 1'b0;
          M_PADDR   <= '0;
          M_PWDATA  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_apb_wbuf.sv
// Bench for vmicro16_apb_wbuf: APB upstream driver, downstream
// slave memory model and write/read scoreboards.
module tb_vmicro16_apb_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] S_PADDR;
  logic        S_PWRITE;
  logic        S_PSELx;
  logic        S_PENABLE;
  logic [15:0] S_PWDATA;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic [15:0] M_PADDR;
  logic        M_PWRITE;
  logic        M_PSELx;
  logic        M_PENABLE;
  logic [15:0] M_PWDATA;
  logic [15:0] M_PRDATA;
  logic        M_PREADY;
  logic        wb_idle;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [15:0] smem [0:255];

  always #5 clk = ~clk;

  assign M_PRDATA = smem[M_PADDR[7:0]];

  vmicro16_apb_wbuf dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (S_PADDR),
    .S_PWRITE  (S_PWRITE),
    .S_PSELx   (S_PSELx),
    .S_PENABLE (S_PENABLE),
    .S_PWDATA  (S_PWDATA),
    .S_PRDATA  (S_PRDATA),
    .S_PREADY  (S_PREADY),
    .M_PADDR   (M_PADDR),
    .M_PWRITE  (M_PWRITE),
    .M_PSELx   (M_PSELx),
    .M_PENABLE (M_PENABLE),
    .M_PWDATA  (M_PWDATA),
    .M_PRDATA  (M_PRDATA),
    .M_PREADY  (M_PREADY),
    .wb_idle   (wb_idle)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [15:0] a,
                        input logic [15:0] d,
                        output int w);
    exp_wr.push_back({a, d});
    S_PSELx   = 1'b1;
    S_PENABLE = 1'b0;
    S_PWRITE  = 1'b1;
    S_PADDR   = a;
    S_PWDATA  = d;
    @(negedge clk);
    S_PENABLE = 1'b1;
    #1;
    w = 0;
    while (!S_PREADY && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("wr_ack", 32'(S_PREADY), 1);
    @(negedge clk);
    S_PSELx   = 1'b0;
    S_PENABLE = 1'b0;
  endtask

  task automatic apb_rd(input logic [15:0] a,
                        input logic [15:0] e,
                        output int lat);
    exp_rd.push_back(e);
    S_PSELx   = 1'b1;
    S_PENABLE = 1'b0;
    S_PWRITE  = 1'b0;
    S_PADDR   = a;
    @(negedge clk);
    S_PENABLE = 1'b1;
    #1;
    lat = 0;
    while (!S_PREADY && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("rd_ack", 32'(S_PREADY), 1);
    check("rd_data", 32'(S_PRDATA), 32'(exp_rd.pop_front()));
    @(negedge clk);
    S_PSELx   = 1'b0;
    S_PENABLE = 1'b0;
    #1;
    check("rd_pulse", 32'(S_PREADY), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    #1;
    while (!wb_idle && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", 32'(wb_idle), 1);
  endtask

  // downstream slave: memory model plus write-order scoreboard
  initial begin
    for (int i = 0; i < 256; i++)
      smem[i] = 16'h0000;
    smem[8'h20] = 16'h1234;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && M_PSELx && !M_PENABLE && !M_PWRITE)
        check("rd_order", 32'(exp_wr.size()), 0);
      if (!reset && M_PSELx && M_PENABLE && M_PREADY && M_PWRITE) begin
        if (exp_wr.size() == 0)
          check("wr_extra", 32'(exp_wr.size()), 1);
        else
          check("wr_seq", {M_PADDR, M_PWDATA}, exp_wr.pop_front());
        smem[M_PADDR[7:0]] = M_PWDATA;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int lat;
    logic [1:0] wp;
    logic [1:0] rp;
    reset     = 1'b1;
    S_PADDR   = '0;
    S_PWDATA  = '0;
    S_PWRITE  = 1'b0;
    S_PSELx   = 1'b0;
    S_PENABLE = 1'b0;
    M_PREADY  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_psel", 32'(M_PSELx), 0);
    check("rst_pen", 32'(M_PENABLE), 0);
    check("rst_pready", 32'(S_PREADY), 0);
    check("rst_idle", 32'(wb_idle), 1);
    check("rst_paddr", 32'(M_PADDR), 0);
    check("rst_prdata", 32'(S_PRDATA), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single write and its downstream timing
    apb_wr(16'h0810, 16'hBEEF, w);
    check("wr1_wait", 32'(w), 0);
    @(negedge clk);
    #1;
    check("wr1_setup_sel", 32'(M_PSELx), 1);
    check("wr1_setup_en", 32'(M_PENABLE), 0);
    check("wr1_addr", 32'(M_PADDR), 32'h0810);
    check("wr1_data", 32'(M_PWDATA), 32'hBEEF);
    check("wr1_write", 32'(M_PWRITE), 1);
    check("wr1_busy", 32'(wb_idle), 0);
    @(negedge clk);
    #1;
    check("wr1_access", 32'(M_PENABLE), 1);
    @(negedge clk);
    #1;
    check("wr1_idle", 32'(wb_idle), 1);
    check("wr1_sel_off", 32'(M_PSELx), 0);

    // fill to full and stall the fifth write
    M_PREADY = 1'b0;
    fork
      begin
        int w5;
        for (int i = 1; i <= 5; i++) begin
          apb_wr(16'h0900 + 16'(2 * i), 16'(i), w5);
          if (i <= 4)
            check("fill_wait", 32'(w5), 0);
          else
            check("fill_stall", 32'(w5 >= 2), 1);
        end
      end
      begin
        repeat (14) @(negedge clk);
        M_PREADY = 1'b1;
        @(negedge clk);
        M_PREADY = 1'b0;
      end
    join
    M_PREADY = 1'b1;
    wait_idle(100);

    // read behind a queued write
    M_PREADY = 1'b0;
    apb_wr(16'h0800, 16'hAAAA, w);
    fork
      apb_rd(16'h0800, 16'hAAAA, lat);
      begin
        repeat (6) @(negedge clk);
        M_PREADY = 1'b1;
      end
    join
    wait_idle(50);

    // read latency on an empty buffer
    apb_rd(16'h0820, 16'h1234, lat);
    check("rd_lat", 32'(lat), 4);
    wait_idle(50);

    // push and pop in the same cycle
    @(negedge clk);
    M_PREADY = 1'b0;
    apb_wr(16'h0840, 16'h0001, w);
    apb_wr(16'h0842, 16'h0002, w);
    exp_wr.push_back({16'h0844, 16'h0003});
    S_PSELx   = 1'b1;
    S_PENABLE = 1'b0;
    S_PWRITE  = 1'b1;
    S_PADDR   = 16'h0844;
    S_PWDATA  = 16'h0003;
    @(negedge clk);
    S_PENABLE = 1'b1;
    M_PREADY  = 1'b1;
    #1;
    check("col_cnt_pre", 32'(dut.u_fifo.count), 2);
    check("col_access", 32'(M_PENABLE), 1);
    check("col_ack", 32'(S_PREADY), 1);
    wp = dut.u_fifo.wr_ptr;
    rp = dut.u_fifo.rd_ptr;
    @(negedge clk);
    S_PSELx   = 1'b0;
    S_PENABLE = 1'b0;
    M_PREADY  = 1'b0;
    #1;
    check("col_cnt", 32'(dut.u_fifo.count), 2);
    check("col_wptr", 32'(dut.u_fifo.wr_ptr), 32'(2'(wp + 2'd1)));
    check("col_rptr", 32'(dut.u_fifo.rd_ptr), 32'(2'(rp + 2'd1)));
    M_PREADY = 1'b1;
    wait_idle(100);

    // reset in the middle of a downstream access
    @(negedge clk);
    M_PREADY = 1'b0;
    apb_wr(16'h0850, 16'h0011, w);
    apb_wr(16'h0852, 16'h0022, w);
    apb_wr(16'h0854, 16'h0033, w);
    @(negedge clk);
    #1;
    check("mid_access", 32'(M_PENABLE), 1);
    check("mid_cnt", 32'(dut.u_fifo.count), 3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sel", 32'(M_PSELx), 0);
    check("mid_rst_en", 32'(M_PENABLE), 0);
    check("mid_rst_idle", 32'(wb_idle), 1);
    check("mid_rst_cnt", 32'(dut.u_fifo.count), 0);
    exp_wr.delete();
    @(negedge clk);
    reset    = 1'b0;
    M_PREADY = 1'b1;
    @(negedge clk);
    apb_wr(16'h0860, 16'h5A5A, w);
    check("post_rst_wait", 32'(w), 0);
    wait_idle(50);
    check("post_rst_mem", 32'(smem[8'h60]), 32'h5A5A);

    repeat (4) @(negedge clk);
    check("wr_left", 32'(exp_wr.size()), 0);
    check("rd_left", 32'(exp_rd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
